uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_BURST, default 4, meaning the maximum number of bytes accepted per grant before forced release.
REQ-002 The block SHALL have parameter IDLE_TIMEOUT, default 8, meaning the consecutive granted-but-invalid cycles before forced release.
REQ-003 Port Clock  input  1  system clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port req0_data  input  8  byte from requester 0 (CPU MMIO store to UART TX register).
REQ-006 Port req0_valid  input  1  requester 0 has a byte.
REQ-007 Port req0_last  input  1  requester 0 byte is the final byte of its frame.
REQ-008 Port req0_ready  output  1  requester 0 byte accepted this cycle.
REQ-009 Ports req1_data/req1_valid/req1_last/req1_ready SHALL mirror REQ-005..008 for requester 1 (hardware status/counter reporter).
REQ-010 Port uart_din  output  8  byte to UART DataIn.
REQ-011 Port uart_din_valid  output  1  to UART DataInValid.
REQ-012 Port uart_din_ready  input  1  from UART DataInReady.
REQ-013 Port grant  output  2  one-hot current owner; 2'b00 when none.

Function
REQ-014 The controller SHALL implement states IDLE, GRANT0, GRANT1.
REQ-015 In IDLE: grant=00, uart_din_valid=0, uart_din=0, both readys=0.
REQ-016 In IDLE with exactly one reqN_valid=1, next state SHALL be GRANTN (one-cycle arbitration latency, no transfer in the arbitration cycle).
REQ-017 In IDLE with both valid, the winner SHALL be the requester indicated by a 1-bit priority pointer; pointer reset value selects requester 0.
REQ-018 In GRANTN: uart_din=reqN_data, uart_din_valid=reqN_valid, reqN_ready=uart_din_ready, other requester's ready=0 (combinational pass-through).
REQ-019 A transfer SHALL occur on a cycle with state GRANTN, reqN_valid=1, uart_din_ready=1.
REQ-020 A burst counter SHALL clear on entry to GRANTN and increment by 1 per transfer.
REQ-021 A transfer with reqN_last=1 SHALL end the grant: next state IDLE.
REQ-022 A transfer that brings the burst counter to MAX_BURST SHALL end the grant even when reqN_last=0.
REQ-023 An idle counter SHALL count consecutive GRANTN cycles with reqN_valid=0, clear on any cycle with reqN_valid=1; on reaching IDLE_TIMEOUT the grant SHALL end (next state IDLE, no transfer).
REQ-024 On every grant end the priority pointer SHALL point to the other requester; it SHALL be unchanged otherwise.
REQ-025 Grant end SHALL always pass through IDLE (one bubble cycle); back-to-back grant without IDLE is forbidden.
REQ-026 A requester's valid/data/last changes while not granted SHALL have no effect on outputs.
REQ-027 Simultaneous last=1 and burst-limit on one transfer SHALL count as a single grant end (one pointer toggle).

Reset
REQ-028 On rst=1 at a rising edge: state=IDLE, pointer=0, burst and idle counters=0; outputs per REQ-015 from the following cycle.
REQ-029 rst mid-grant SHALL abandon the grant with no further transfers; the in-flight UART byte (already accepted) is not recalled.
REQ-030 rst SHALL take priority over all other transitions in the same cycle.

Verification
REQ-031 Only req0_valid=1 with data 0xAA, last=1, uart_din_ready=1 -> grant=01 one cycle after, uart_din=0xAA, req0_ready=1 for one cycle, then IDLE, pointer=1.
REQ-032 Both valid continuously, last=1 every byte, ready=1 -> grants alternate 01,00,10,00,01..., bytes interleave req0,req1,req0.
REQ-033 req1 streams 6 bytes with last=0, MAX_BURST=4, req0 valid -> req1 sends 4 bytes, IDLE, req0 granted next, req1 resumes after req0 ends.
REQ-034 GRANT0 with req0_valid dropped to 0 for 8 cycles, req1 valid -> release to IDLE after 8th cycle, GRANT1 next cycle, no transfer from req0.
REQ-035 uart_din_ready=0 for 10 cycles during GRANT1 with req1_valid=1 -> grant held (idle counter stays 0), req1_ready=0, byte transferred on first ready cycle.
REQ-036 rst asserted mid-burst after 2 of 4 bytes -> next cycle grant=00, uart_din_valid=0, pointer=0, counters=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter in front of a UART transmitter: one-hot grant, alternating
// priority, and grants released on frame end, burst limit or requester inactivity.
module uart_tx_arbiter #(
  parameter int MAX_BURST    = 4,
  parameter int IDLE_TIMEOUT = 8
) (
  input  logic       Clock,
  input  logic       rst,
  input  logic [7:0] req0_data,
  input  logic       req0_valid,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_valid,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [7:0] uart_din,
  output logic       uart_din_valid,
  input  logic       uart_din_ready,
  output logic [1:0] grant
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [BW-1:0] BURST_LIM = BW'(MAX_BURST);
  localparam logic [IW-1:0] IDLE_LIM  = IW'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_e;

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [IW-1:0] idle_q, idle_d;

  logic sel_valid, sel_last, xfer, burst_hit, idle_hit;

  // Datapath is a pure pass-through of the granted requester; no data is stored here.
  always_comb begin
    uart_din       = '0;
    uart_din_valid = 1'b0;
    req0_ready     = 1'b0;
    req1_ready     = 1'b0;
    grant          = 2'b00;
    case (state_q)
      GRANT0: begin
        grant          = 2'b01;
        uart_din       = req0_data;
        uart_din_valid = req0_valid;
        req0_ready     = uart_din_ready;
      end
      GRANT1: begin
        grant          = 2'b10;
        uart_din       = req1_data;
        uart_din_valid = req1_valid;
        req1_ready     = uart_din_ready;
      end
      default: ;
    endcase
  end

  always_comb begin
    sel_valid = (state_q == GRANT1) ? req1_valid : req0_valid;
    sel_last  = (state_q == GRANT1) ? req1_last  : req0_last;
    xfer      = (state_q != IDLE) && sel_valid && uart_din_ready;
    burst_hit = (burst_q + 1'b1) == BURST_LIM;
    idle_hit  = (idle_q + 1'b1) == IDLE_LIM;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    burst_d = burst_q;
    idle_d  = idle_q;
    case (state_q)
      IDLE: begin
        burst_d = '0;
        idle_d  = '0;
        if (req0_valid && (!req1_valid || !ptr_q)) state_d = GRANT0;
        else if (req1_valid)                       state_d = GRANT1;
      end
      GRANT0, GRANT1: begin
        // last and burst limit on the same transfer are a single release
        if (xfer) begin
          burst_d = burst_q + 1'b1;
          idle_d  = '0;
          if (sel_last || burst_hit) begin
            state_d = IDLE;
            ptr_d   = (state_q == GRANT0);
          end
        end else if (!sel_valid) begin
          idle_d = idle_q + 1'b1;
          if (idle_hit) begin
            state_d = IDLE;
            ptr_d   = (state_q == GRANT0);
          end
        end else begin
          idle_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      burst_q <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
      idle_q  <= idle_d;
    end
  end

endmodule
